// File: rtl/nios2_mul_pkg.sv
// Shared definitions for the Nios II mul/mulx sequencer: op encodings,
// sequencer state encoding, accumulator width and nominal latencies.
package nios2_mul_pkg;

  // Custom-instruction op field encoding.
  localparam logic [1:0] OP_MUL    = 2'b00;  // low word of the product
  localparam logic [1:0] OP_MULXUU = 2'b01;  // high word, unsigned x unsigned
  localparam logic [1:0] OP_MULXSU = 2'b10;  // high word, signed x unsigned
  localparam logic [1:0] OP_MULXSS = 2'b11;  // high word, signed x signed

  // Cycles from driving the cell operands to its registered result.
  // The sequencer's state chain is built around a value of 1.
  localparam int CELL_LAT = 1;

  // Width of the partial-product accumulator (full 32x32 product).
  localparam int ACC_W = 64;

  // Edges from the start-sampling edge to the edge that raises done.
  localparam int MUL_LAT_FULL = 6;
  localparam int MUL_LAT_LO   = 2;

  // Sequencer states. P_LO is only reachable in the early-low-word build.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_ACC  = 3'd5,
    ST_FIX  = 3'd6,
    ST_P_LO = 3'd7
  } mul_state_e;

endpackage : nios2_mul_pkg

// File: rtl/nios2_mulx_fix.sv
// Signed correction of the high word of an unsigned 32x32 product.
// Subtracting the other operand once for each negative signed operand
// turns the unsigned high word into the signed (or mixed) high word,
// modulo 2^32. Purely combinational so it can be exercised on its own.
module nios2_mulx_fix
  import nios2_mul_pkg::*;
(
  input  logic [31:0] hi,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic [1:0]  op,
  output logic [31:0] hi_fixed
);

  logic [31:0] corr;

  // Build the correction term from the operand sign bits, then subtract it.
  always_comb begin
    corr = 32'h0;
    if ((op == OP_MULXSU || op == OP_MULXSS) && opa[31]) begin
      corr = opb;
    end
    if (op == OP_MULXSS && opb[31]) begin
      corr = corr + opa;
    end
    hi_fixed = hi - corr;
  end

endmodule : nios2_mulx_fix

// File: rtl/nios2_nios2_qsys_0_mulx_seq.sv
// Multi-pass sequencer around the registered 16x16-based multiply cell.
// Issues four zero-extended 16x16 partial products (P0..P3), accumulates
// the 64-bit sum one cycle behind each issue, applies the signed
// correction in FIX, and registers the low or high word as the result.
//
// Optional build macro: NIOS2_MUL_EARLY_LO_EN. When defined, op=mul sends
// the full operands to the cell once and takes its low 32 bits directly
// through state P_LO (done two edges after start instead of six).
//
// Handshake: start is a one-cycle request that is looked at only while
// the sequencer is idle (busy=0); a start seen while busy is dropped.
// done is a one-cycle pulse in the cycle after FIX and result holds its
// value until the next completed operation. flush cancels an operation in
// flight on the next edge without raising done; in idle it masks start.
module nios2_nios2_qsys_0_mulx_seq
  import nios2_mul_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [31:0]      opa,
  input  logic [31:0]      opb,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic [31:0]      A_mul_src1,
  output logic [31:0]      A_mul_src2,
  input  logic [31:0]      A_mul_cell_result,
  output mul_state_e       state_dbg
);

  mul_state_e        state;
  logic [1:0]        op_q;
  logic [31:0]       opa_q;
  logic [31:0]       opb_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  cell_ext;
  logic [31:0]       hi_fixed;
  logic              take_early;
  logic              lo_wait;

  assign state_dbg = state;
  assign cell_ext  = ACC_W'(A_mul_cell_result);

  // Whether a start goes down the single-pass low-word path.
`ifdef NIOS2_MUL_EARLY_LO_EN
  assign take_early = (op == OP_MUL);
`else
  assign take_early = 1'b0;
`endif

  nios2_mulx_fix u_fix (
    .hi       (acc[ACC_W-1 -: 32]),
    .opa      (opa_q),
    .opb      (opb_q),
    .op       (op_q),
    .hi_fixed (hi_fixed)
  );

  // Sequencer: state, operand capture, cell operand registers,
  // accumulator and registered outputs in one clocked block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= 2'b00;
      opa_q      <= 32'h0;
      opb_q      <= 32'h0;
      acc        <= '0;
      lo_wait    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 32'h0;
      A_mul_src1 <= 32'h0;
      A_mul_src2 <= 32'h0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && flush) begin
        // Pipeline kill: abandon the operation, keep the old result.
        state      <= ST_IDLE;
        busy       <= 1'b0;
        lo_wait    <= 1'b0;
        A_mul_src1 <= 32'h0;
        A_mul_src2 <= 32'h0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !flush) begin
              op_q  <= op;
              opa_q <= opa;
              opb_q <= opb;
              acc   <= '0;
              busy  <= 1'b1;
              if (take_early) begin
                // Full operands; the cell's low 32 bits are the mul result.
                state      <= ST_P_LO;
                lo_wait    <= 1'b0;
                A_mul_src1 <= opa;
                A_mul_src2 <= opb;
              end else begin
                // First pass uses the live inputs since they are being
                // captured on this same edge.
                state      <= ST_P0;
                A_mul_src1 <= {16'h0, opa[15:0]};
                A_mul_src2 <= {16'h0, opb[15:0]};
              end
            end
          end
          ST_P0: begin
            state      <= ST_P1;
            A_mul_src1 <= {16'h0, opa_q[15:0]};
            A_mul_src2 <= {16'h0, opb_q[31:16]};
          end
          ST_P1: begin
            // a_lo*b_lo from the P0 issue is valid now.
            state      <= ST_P2;
            acc        <= acc + cell_ext;
            A_mul_src1 <= {16'h0, opa_q[31:16]};
            A_mul_src2 <= {16'h0, opb_q[15:0]};
          end
          ST_P2: begin
            // a_lo*b_hi from the P1 issue.
            state      <= ST_P3;
            acc        <= acc + (cell_ext << 16);
            A_mul_src1 <= {16'h0, opa_q[31:16]};
            A_mul_src2 <= {16'h0, opb_q[31:16]};
          end
          ST_P3: begin
            // a_hi*b_lo from the P2 issue; no further passes to issue.
            state      <= ST_ACC;
            acc        <= acc + (cell_ext << 16);
            A_mul_src1 <= 32'h0;
            A_mul_src2 <= 32'h0;
          end
          ST_ACC: begin
            // a_hi*b_hi from the P3 issue completes the 64-bit product.
            state <= ST_FIX;
            acc   <= acc + (cell_ext << 32);
          end
          ST_FIX: begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= (op_q == OP_MUL) ? acc[31:0] : hi_fixed;
          end
          ST_P_LO: begin
            if (!lo_wait) begin
              // Cell samples the operands on this edge; result follows.
              lo_wait    <= 1'b1;
              A_mul_src1 <= 32'h0;
              A_mul_src2 <= 32'h0;
            end else begin
              state   <= ST_IDLE;
              lo_wait <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              result  <= A_mul_cell_result;
            end
          end
          default: begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            A_mul_src1 <= 32'h0;
            A_mul_src2 <= 32'h0;
          end
        endcase
      end
    end
  end

endmodule : nios2_nios2_qsys_0_mulx_seq

// File: tb/tb_nios2_nios2_qsys_0_mulx_seq.sv
// Bench for the mul/mulx sequencer: a registered multiply-cell model,
// a vector table of known products, hand-written multi-cycle sequences
// (busy re-start, back-to-back, flush, async reset) and randomized ops
// against a 64-bit arithmetic reference with an expected-value queue.
module tb_nios2_nios2_qsys_0_mulx_seq;
  import nios2_mul_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] A_mul_src1;
  logic [31:0] A_mul_src2;
  logic [31:0] A_mul_cell_result;
  mul_state_e  state_dbg;

  always #5 clk = ~clk;

  // Registered multiply cell, one cycle of latency, low 32 bits.
  always @(posedge clk) A_mul_cell_result <= A_mul_src1 * A_mul_src2;

  nios2_nios2_qsys_0_mulx_seq dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .flush             (flush),
    .op                (op),
    .opa               (opa),
    .opb               (opb),
    .busy              (busy),
    .done              (done),
    .result            (result),
    .A_mul_src1        (A_mul_src1),
    .A_mul_src2        (A_mul_src2),
    .A_mul_cell_result (A_mul_cell_result),
    .state_dbg         (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] src1_log [0:31];
  logic [31:0] src2_log [0:31];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  // Product from plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] ref_model(input logic [1:0] f_op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f_op == 2'b10 || f_op == 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (f_op == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (f_op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] f_op);
`ifdef NIOS2_MUL_EARLY_LO_EN
    return (f_op == 2'b00) ? 2 : 6;
`else
    return (f_op == 2'b00) ? 6 : 6;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 32) begin
      src1_log[cyc] = A_mul_src1;
      src2_log[cyc] = A_mul_src2;
    end
  endtask

  // Present a one-cycle start; returns #1 after the sampling edge.
  task automatic issue(input logic [1:0] t_op, input logic [31:0] t_a,
                       input logic [31:0] t_b);
    op    = t_op;
    opa   = t_a;
    opb   = t_b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    src1_log[0] = A_mul_src1;
    src2_log[0] = A_mul_src2;
  endtask

  // Step until done (bounded); ends in the done cycle.
  task automatic wait_done(output logic [31:0] res, output int lat);
    bit seen;
    seen = 1'b0;
    res  = 32'h0;
    lat  = 0;
    while (!seen && cyc < 30) begin
      step();
      if (done) begin
        seen = 1'b1;
        res  = result;
        lat  = cyc;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout actual=none expected=done within 30 cycles");
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] res;
    logic [31:0] old_res;
    logic [31:0] exp_v;
    int          lat;
    int          done_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
    vecs[5] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
    vecs[6] = '{2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};

    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    opa   = 32'h0;
    opb   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   {31'h0, busy}, 32'h0);
    check("reset_done",   {31'h0, done}, 32'h0);
    check("reset_result", result,        32'h0);
    check("reset_src1",   A_mul_src1,    32'h0);
    check("reset_src2",   A_mul_src2,    32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table of known products.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].op));
      if (i == 0) begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("vec0_src1_pass%0d", k), src1_log[k], 32'h0000_FFFF);
          check($sformatf("vec0_src2_pass%0d", k), src2_log[k], 32'h0000_FFFF);
        end
        check("vec0_src1_after", src1_log[4], 32'h0);
      end
      step();
      check($sformatf("vec%0d_done_width", i), {31'h0, done}, 32'h0);
    end

    // start re-pulsed while busy with other operands is dropped.
    issue(2'b11, 32'h8000_0000, 32'h8000_0000);
    step();
    op = 2'b01; opa = 32'h1234_5678; opb = 32'h9ABC_DEF0; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(res, lat);
    check("busy_restart_result",  res, 32'h4000_0000);
    check("busy_restart_latency", lat, 6);

    // New start in the done cycle is accepted.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("b2b_busy", {31'h0, busy}, 32'h1);
    check("b2b_done_low", {31'h0, done}, 32'h0);
    wait_done(res, lat);
    check("b2b_result",  res, 32'hFFFF_FFFE);
    check("b2b_latency", lat, 6);
    step();

    // flush in P2: no done, busy drops, result kept.
    old_res = result;
    issue(2'b01, 32'h0000_0005, 32'h0000_0007);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy",   {31'h0, busy}, 32'h0);
    check("flush_src1",   A_mul_src1,    32'h0);
    check("flush_src2",   A_mul_src2,    32'h0);
    done_cnt = 0;
    repeat (8) begin
      step();
      if (done) done_cnt++;
    end
    check("flush_no_done", done_cnt, 0);
    check("flush_result_kept", result, old_res);

    // flush together with start in idle: flush wins.
    op = 2'b01; opa = 32'h3; opb = 32'h3; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'h0, busy}, 32'h0);

    // Async reset while in ACC.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) step();
    #2;
    reset = 1'b1;
    #1;
    check("areset_busy",   {31'h0, busy}, 32'h0);
    check("areset_done",   {31'h0, done}, 32'h0);
    check("areset_result", result,        32'h0);
    check("areset_src1",   A_mul_src1,    32'h0);
    check("areset_src2",   A_mul_src2,    32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    issue(2'b01, 32'h0001_0000, 32'h0001_0000);
    wait_done(res, lat);
    check("post_reset_result",  res, 32'h0000_0001);
    check("post_reset_latency", lat, 6);

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       r_a = 32'h8000_0000;
        1:       r_a = 32'hFFFF_FFFF;
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       r_b = 32'h0;
        1:       r_b = 32'h8000_0000;
        default: r_b = $urandom;
      endcase
      exp_q.push_back(ref_model(r_op, r_a, r_b));
      issue(r_op, r_a, r_b);
      wait_done(res, lat);
      exp_v = exp_q.pop_front();
      check($sformatf("rand%0d_op%0d_result", n, r_op), res, exp_v);
      check($sformatf("rand%0d_latency", n), lat, exp_lat(r_op));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule : tb_nios2_nios2_qsys_0_mulx_seq
